lcd_line_sequencer: RTL and testbench

Upstream command/data sequencer for the two-line I2C character display. Holds a 32-character text buffer (2 lines × 16) and, on `start`, runs the init → clear → display-on → line 1 → line 2 sequence as a stream of bytes. The bytes go to the I2C byte transmitter over a valid/ready handshake. The transmitter owns START, the slave address (0x3C), ACK sampling and STOP; this block only decides byte content and transaction boundaries.

---
 rtl/lcd_pkg.sv | 48 ++++
 rtl/lcd_text_buffer.sv | 32 +++
 rtl/lcd_line_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_lcd_line_sequencer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared types and byte constants for the two-line I2C character display sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package lcd_pkg;

  // Sequencer states. Every transmitting state produces exactly one I2C transaction.
  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_CLEAR    = 4'd1,
    S_WAIT_CLR = 4'd2,
    S_ON       = 4'd3,
    S_L1_ADDR  = 4'd4,
    S_L1_DATA  = 4'd5,
    S_L2_ADDR  = 4'd6,
    S_L2_DATA  = 4'd7,
    S_DONE     = 4'd8,
    S_ERROR    = 4'd9
  } state_t;

  // Control bytes: select command register or display data RAM.
  localparam logic [7:0] CTRL_CMD  = 8'h00;
  localparam logic [7:0] CTRL_DATA = 8'h40;

  // Display commands.
  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_ON    = 8'h0C;
  localparam logic [7:0] CMD_LINE1 = 8'h80;
  localparam logic [7:0] CMD_LINE2 = 8'hC0;

  // Text buffer geometry and fill character.
  localparam int         BUF_AW     = 5;
  localparam int         BUF_DEPTH  = 32;
  localparam logic [7:0] CHAR_SPACE = 8'h20;

  // Second byte of each two-byte command transaction.
  function automatic logic [7:0] cmd_byte(input state_t s);
    logic [7:0] b;
    case (s)
      S_CLEAR:   b = CMD_CLEAR;
      S_ON:      b = CMD_ON;
      S_L1_ADDR: b = CMD_LINE1;
      S_L2_ADDR: b = CMD_LINE2;
      default:   b = CTRL_CMD;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/lcd_text_buffer.sv
// 32x8 character buffer: one synchronous write port, one combinational read port.
// Latency: write visible on read port the cycle after the strobe; read is combinational.
// Backpressure: none, writes are always accepted.
// Ports: clk/rst_low (async active-low, fills buffer with spaces),
//        i_we/i_waddr/i_wdata write port, i_raddr/o_rdata read port.
module lcd_text_buffer
  import lcd_pkg::*;
(
  input  logic              clk,
  input  logic              rst_low,
  input  logic              i_we,
  input  logic [BUF_AW-1:0] i_waddr,
  input  logic [7:0]        i_wdata,
  input  logic [BUF_AW-1:0] i_raddr,
  output logic [7:0]        o_rdata
);

  logic [7:0] r_mem [BUF_DEPTH];

  always_ff @(posedge clk or negedge rst_low) begin
    if (!rst_low) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        r_mem[i] <= CHAR_SPACE;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/lcd_line_sequencer.sv
// Streams clear / display-on / line-1 / line-2 transactions from a 2x16 text buffer to an I2C byte transmitter.
// Latency: first byte valid the cycle after start; zero-bubble between bytes except the CLEAR_WAIT idle gap.
// Backpressure: valid/ready; the staged byte and its first/last flags hold while tx_ready is low.
// Ports: clk, rst_low (async active-low); start pulse; char_we/char_addr/char_data buffer write;
//        tx_valid/tx_byte/tx_first/tx_last/tx_ready/tx_nack transmitter side; busy/done/error status.
module lcd_line_sequencer
  import lcd_pkg::*;
#(
  parameter int LINE_LEN   = 16,
  parameter int CLEAR_WAIT = 2000
) (
  input  logic       clk,
  input  logic       rst_low,
  input  logic       start,
  input  logic       char_we,
  input  logic [4:0] char_addr,
  input  logic [7:0] char_data,
  output logic       tx_valid,
  output logic [7:0] tx_byte,
  output logic       tx_first,
  output logic       tx_last,
  input  logic       tx_ready,
  input  logic       tx_nack,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int WCW = (CLEAR_WAIT > 1) ? $clog2(CLEAR_WAIT) : 1;

  state_t              r_state;
  logic                r_tx_valid;
  logic [7:0]          r_tx_byte;
  logic                r_tx_first;
  logic                r_tx_last;
  logic                r_busy;
  logic                r_done;
  logic                r_error;
  logic [4:0]          r_idx;       // characters staged so far in the current line, 0..LINE_LEN
  logic [WCW-1:0]      r_wait_cnt;

  logic                w_hs;
  logic [BUF_AW-1:0]   w_rd_addr;
  logic [7:0]          w_rd_data;

  assign w_hs = r_tx_valid && tx_ready;

  // Line 2 characters live in the upper half of the buffer.
  assign w_rd_addr = (r_state == S_L2_DATA) ? BUF_AW'(LINE_LEN) + r_idx : r_idx;

  lcd_text_buffer u_buf (
    .clk     (clk),
    .rst_low (rst_low),
    .i_we    (char_we),
    .i_waddr (char_addr),
    .i_wdata (char_data),
    .i_raddr (w_rd_addr),
    .o_rdata (w_rd_data)
  );

  always_ff @(posedge clk or negedge rst_low) begin
    if (!rst_low) begin
      r_state    <= S_IDLE;
      r_tx_valid <= 1'b0;
      r_tx_byte  <= 8'h00;
      r_tx_first <= 1'b0;
      r_tx_last  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_idx      <= '0;
      r_wait_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            r_state    <= S_CLEAR;
            r_tx_valid <= 1'b1;
            r_tx_byte  <= CTRL_CMD;
            r_tx_first <= 1'b1;
            r_tx_last  <= 1'b0;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
          end
        end

        S_CLEAR, S_ON, S_L1_ADDR, S_L2_ADDR: begin
          if (tx_nack) begin
            r_state    <= S_ERROR;
            r_tx_valid <= 1'b0;
            r_tx_first <= 1'b0;
            r_tx_last  <= 1'b0;
            r_busy     <= 1'b0;
            r_error    <= 1'b1;
          end else if (w_hs) begin
            if (!r_tx_last) begin
              // Control byte accepted: stage the command that closes the transaction.
              r_tx_byte  <= cmd_byte(r_state);
              r_tx_first <= 1'b0;
              r_tx_last  <= 1'b1;
            end else begin
              case (r_state)
                S_CLEAR: begin
                  r_state    <= S_WAIT_CLR;
                  r_tx_valid <= 1'b0;
                  r_tx_last  <= 1'b0;
                  r_wait_cnt <= '0;
                end
                S_ON: begin
                  r_state    <= S_L1_ADDR;
                  r_tx_byte  <= CTRL_CMD;
                  r_tx_first <= 1'b1;
                  r_tx_last  <= 1'b0;
                end
                S_L1_ADDR: begin
                  r_state    <= S_L1_DATA;
                  r_tx_byte  <= CTRL_DATA;
                  r_tx_first <= 1'b1;
                  r_tx_last  <= 1'b0;
                  r_idx      <= '0;
                end
                default: begin
                  r_state    <= S_L2_DATA;
                  r_tx_byte  <= CTRL_DATA;
                  r_tx_first <= 1'b1;
                  r_tx_last  <= 1'b0;
                  r_idx      <= '0;
                end
              endcase
            end
          end
        end

        S_WAIT_CLR: begin
          if (tx_nack) begin
            r_state <= S_ERROR;
            r_busy  <= 1'b0;
            r_error <= 1'b1;
          end else if (r_wait_cnt == WCW'(CLEAR_WAIT - 1)) begin
            r_state    <= S_ON;
            r_tx_valid <= 1'b1;
            r_tx_byte  <= CTRL_CMD;
            r_tx_first <= 1'b1;
            r_tx_last  <= 1'b0;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end

        S_L1_DATA, S_L2_DATA: begin
          if (tx_nack) begin
            r_state    <= S_ERROR;
            r_tx_valid <= 1'b0;
            r_tx_first <= 1'b0;
            r_tx_last  <= 1'b0;
            r_busy     <= 1'b0;
            r_error    <= 1'b1;
          end else if (w_hs) begin
            if (r_tx_last) begin
              if (r_state == S_L1_DATA) begin
                r_state    <= S_L2_ADDR;
                r_tx_byte  <= CTRL_CMD;
                r_tx_first <= 1'b1;
                r_tx_last  <= 1'b0;
              end else begin
                r_state    <= S_DONE;
                r_tx_valid <= 1'b0;
                r_tx_last  <= 1'b0;
                r_busy     <= 1'b0;
                r_done     <= 1'b1;
              end
            end else begin
              // Snapshot the character now; later buffer writes only affect the next refresh.
              r_tx_byte  <= w_rd_data;
              r_tx_first <= 1'b0;
              r_tx_last  <= (r_idx == 5'(LINE_LEN - 1));
              r_idx      <= r_idx + 1'b1;
            end
          end
        end

        default: begin
          r_state    <= S_IDLE;
          r_tx_valid <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign tx_valid = r_tx_valid;
  assign tx_byte  = r_tx_byte;
  assign tx_first = r_tx_first;
  assign tx_last  = r_tx_last;
  assign busy     = r_busy;
  assign done     = r_done;
  assign error    = r_error;

endmodule

// File: tb/tb_lcd_line_sequencer.sv
module tb_lcd_line_sequencer;

  localparam int CW = 2000;

  logic       clk = 1'b0;
  logic       rst_low;
  logic       start;
  logic       char_we;
  logic [4:0] char_addr;
  logic [7:0] char_data;
  logic       tx_valid;
  logic [7:0] tx_byte;
  logic       tx_first;
  logic       tx_last;
  logic       tx_ready;
  logic       tx_nack;
  logic       busy;
  logic       done;
  logic       error;

  lcd_line_sequencer #(.LINE_LEN(16), .CLEAR_WAIT(CW)) dut (
    .clk       (clk),
    .rst_low   (rst_low),
    .start     (start),
    .char_we   (char_we),
    .char_addr (char_addr),
    .char_data (char_data),
    .tx_valid  (tx_valid),
    .tx_byte   (tx_byte),
    .tx_first  (tx_first),
    .tx_last   (tx_last),
    .tx_ready  (tx_ready),
    .tx_nack   (tx_nack),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] b;
    logic       f;
    logic       l;
    logic       e;   // final byte of a full sequence
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] mbuf [32];
  int         checks   = 0;
  int         failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic push(input logic [7:0] b, input logic f, input logic l, input logic e);
    exp_t x;
    x.b = b; x.f = f; x.l = l; x.e = e;
    exp_q.push_back(x);
  endtask

  // Expected 42-byte stream from the current model buffer contents.
  task automatic push_seq();
    push(8'h00, 1'b1, 1'b0, 1'b0); push(8'h01, 1'b0, 1'b1, 1'b0);
    push(8'h00, 1'b1, 1'b0, 1'b0); push(8'h0C, 1'b0, 1'b1, 1'b0);
    push(8'h00, 1'b1, 1'b0, 1'b0); push(8'h80, 1'b0, 1'b1, 1'b0);
    push(8'h40, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) push(mbuf[i], 1'b0, i == 15, 1'b0);
    push(8'h00, 1'b1, 1'b0, 1'b0); push(8'hC0, 1'b0, 1'b1, 1'b0);
    push(8'h40, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) push(mbuf[16+i], 1'b0, i == 15, i == 15);
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic       prev_stall = 1'b0;
  logic [7:0] prev_b;
  logic       prev_f, prev_l;
  int         gap = 0;
  logic       expect_done = 1'b0;

  always @(negedge clk) begin
    if (!rst_low) begin
      prev_stall  = 1'b0;
      gap         = 0;
      expect_done = 1'b0;
    end else begin
      if (expect_done) begin
        check("done_after_last", 32'({done, busy, tx_valid}), 32'b100);
        expect_done = 1'b0;
      end
      if (prev_stall)
        check("stall_hold", 32'({tx_valid, tx_byte, tx_first, tx_last}),
              32'({1'b1, prev_b, prev_f, prev_l}));
      if (busy && !tx_valid) begin
        gap++;
      end else begin
        if (tx_valid && gap != 0) check("clear_wait_gap", 32'(gap), 32'(CW));
        gap = 0;
      end
      if (tx_valid && tx_ready && !tx_nack) begin
        if (exp_q.size() == 0) begin
          check("unexpected_byte", 32'(tx_byte), 32'hFFFF_FFFF);
        end else begin
          exp_t x;
          x = exp_q.pop_front();
          check("stream_byte", 32'({tx_byte, tx_first, tx_last}), 32'({x.b, x.f, x.l}));
          if (x.e) expect_done = 1'b1;
        end
      end
      prev_stall = tx_valid && !tx_ready && !tx_nack;
      prev_b = tx_byte; prev_f = tx_first; prev_l = tx_last;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_start();
    push_seq();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("start_busy_valid", 32'({busy, tx_valid, tx_first}), 32'b111);
    check("start_clears_status", 32'({error, done}), 32'b00);
  endtask

  task automatic run_until_done(input bit rnd);
    int cyc = 0;
    while (!(done || error) && cyc < 30000) begin
      @(posedge clk); #1;
      if (rnd) tx_ready = 1'($urandom_range(0, 1));
      cyc++;
    end
    tx_ready = 1'b1;
    check("seq_done", 32'({done, error, busy}), 32'b100);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_hs(input int n);
    int cnt = 0;
    int cyc = 0;
    while (cnt < n && cyc < 10000) begin
      @(negedge clk);
      cyc++;
      if (tx_valid && tx_ready && !tx_nack) cnt++;
    end
    if (cnt < n) check("handshake_timeout", 32'(cnt), 32'(n));
  endtask

  task automatic write_char(input logic [4:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    char_we = 1'b1; char_addr = a; char_data = d;
    @(posedge clk); #1;
    char_we = 1'b0;
    mbuf[a] = d;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] hello [5];
    logic [7:0] world [5];
    hello = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
    world = '{8'h57, 8'h4F, 8'h52, 8'h4C, 8'h44};
    for (int i = 0; i < 32; i++) mbuf[i] = 8'h20;
    rst_low = 1'b1; start = 1'b0; char_we = 1'b0; char_addr = '0; char_data = '0;
    tx_ready = 1'b1; tx_nack = 1'b0;
    #1 rst_low = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_byte", 32'(tx_byte), 32'd0);
    check("rst_flags", 32'({tx_first, tx_last}), 32'd0);
    check("rst_status", 32'({busy, done, error}), 32'd0);
    rst_low = 1'b1;

    // Blank buffer, always ready.
    do_start();
    run_until_done(1'b0);

    // HELLO / WORLD.
    for (int i = 0; i < 5; i++) write_char(5'(i), hello[i]);
    for (int i = 0; i < 5; i++) write_char(5'(16 + i), world[i]);
    do_start();
    run_until_done(1'b0);

    // Same text, random ready stalls.
    do_start();
    run_until_done(1'b1);

    // NACK while the 5th L1_DATA byte is staged.
    do_start();
    wait_hs(10);
    @(posedge clk); #1;
    tx_ready = 1'b0; tx_nack = 1'b1;
    @(posedge clk); #1;
    tx_nack = 1'b0;
    check("nack_status", 32'({tx_valid, error, busy, done}), 32'b0100);
    check("nack_remaining", 32'(exp_q.size()), 32'd32);
    exp_q.delete();
    tx_ready = 1'b1;
    do_start();
    run_until_done(1'b0);

    // Start pulse mid-L2_DATA is ignored; overwriting staged entry 20 sends the old value.
    do_start();
    wait_hs(30);
    @(posedge clk); #1;
    tx_ready = 1'b0; char_we = 1'b1; char_addr = 5'd20; char_data = 8'h58; start = 1'b1;
    @(posedge clk); #1;
    char_we = 1'b0; start = 1'b0;
    check("mid_start_busy", 32'({busy, tx_valid, tx_byte}), 32'({1'b1, 1'b1, 8'h44}));
    @(posedge clk); #1;
    tx_ready = 1'b1;
    run_until_done(1'b0);
    mbuf[20] = 8'h58;
    do_start();
    run_until_done(1'b0);

    // Async reset during WAIT_CLR.
    do_start();
    wait_hs(2);
    repeat (100) @(posedge clk);
    @(negedge clk); #2;
    rst_low = 1'b0;
    #1;
    check("arst_tx_valid_byte", 32'({tx_valid, tx_byte}), 32'd0);
    check("arst_flags_status", 32'({tx_first, tx_last, busy, done, error}), 32'd0);
    exp_q.delete();
    for (int i = 0; i < 32; i++) mbuf[i] = 8'h20;
    @(posedge clk); #1 rst_low = 1'b1;
    do_start();
    run_until_done(1'b0);

    repeat (5) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
